sd_cmd_responder: RTL and testbench

- Card-side end of the SD CMD line: deserialises 48-bit host command frames, checks them, and serialises a 48-bit short response (R1/R3/R6/R7 format).
- Sits opposite the host command driver; used as the card model in the SD emulation/loopback path and in self-test builds.
- Clocked directly by the SD CLK line; samples and drives on the rising edge.

---
 rtl/sd_cmd_responder.sv | 193 +++++++++++++++++++
 tb/tb_sd_cmd_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit host commands and serialises a 48-bit short response.
// Define SD_CMD_CRC_CHECK_EN to check received CRC7 and generate response CRC7; otherwise the CRC field is 7'h7F.
//
// state | meaning
// IDLE  | line released, waiting for a start bit
// RX    | shifting in the remaining 47 frame bits
// CHECK | one cycle to classify the received frame
// WAIT  | command accepted, counting toward NCR / timeout
// TX    | driving the 48 response bits MSB first
module sd_cmd_responder #(
    parameter int NCR         = 2,
    parameter int NCR_TIMEOUT = 64
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        icmd_sd,
    output logic        ocmd_sd,
    output logic        ocmd_oe,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    output logic        ocmd_valid,
    output logic        ocrc_fail,
    output logic        oframe_err,
    input  logic        irespond,
    input  logic        iskip,
    input  logic [5:0]  iresp_index,
    input  logic [31:0] iresp_arg,
    output logic        obusy
);

    localparam int             CW    = $clog2(NCR_TIMEOUT + 1);
    localparam logic [CW-1:0]  NCR_C = CW'(NCR);
    localparam logic [CW-1:0]  TMO_C = CW'(NCR_TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_TX    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [46:0]   rx_q, rx_d;          // start bit is implicit, frame bits [46:0]
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          resp_vld_q, resp_vld_d;
    logic [47:0]   tx_q, tx_d;
    logic [5:0]    index_q, index_d;
    logic [31:0]   arg_q, arg_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic [6:0]    resp_crc;
    logic          resp_now;

`ifdef SD_CMD_CRC_CHECK_EN
    logic crcf_q, crcf_d;
    logic rx_crc_ok;

    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign resp_crc  = crc7({2'b00, iresp_index, iresp_arg});
    assign rx_crc_ok = (crc7({1'b0, rx_q[46:8]}) == rx_q[7:1]);
    assign ocrc_fail = crcf_q;
`else
    assign resp_crc  = 7'h7F;
    assign ocrc_fail = 1'b0;
`endif

    assign resp_now = resp_vld_q | irespond;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        wcnt_d     = wcnt_q;
        resp_vld_d = resp_vld_q;
        tx_d       = tx_q;
        index_d    = index_q;
        arg_d      = arg_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
        crcf_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!icmd_sd) begin
                    state_d   = S_RX;
                    bit_cnt_d = 6'd1;
                end
            end
            S_RX: begin
                rx_d      = {rx_q[45:0], icmd_sd};
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd47) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d    = S_IDLE;
                resp_vld_d = 1'b0;
                if (!rx_q[0]) begin
                    ferr_d = 1'b1;
                end else if (!rx_q[46]) begin
                    // another card's response on a shared line: ignore it
                    state_d = S_IDLE;
`ifdef SD_CMD_CRC_CHECK_EN
                end else if (!rx_crc_ok) begin
                    crcf_d = 1'b1;
`endif
                end else begin
                    index_d = rx_q[45:40];
                    arg_d   = rx_q[39:8];
                    valid_d = 1'b1;
                    wcnt_d  = CW'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + CW'(1);
                if (iskip) begin
                    state_d = S_IDLE;
                end else begin
                    if (irespond) begin
                        resp_vld_d = 1'b1;
                        tx_d       = {2'b00, iresp_index, iresp_arg, resp_crc, 1'b1};
                    end
                    // wcnt_d is the count of the cycle that would carry the start bit
                    if (resp_now && (wcnt_d >= NCR_C)) begin
                        state_d   = S_TX;
                        bit_cnt_d = 6'd0;
                    end else if (!resp_now && (wcnt_d == TMO_C)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_TX: begin
                tx_d      = {tx_q[46:0], 1'b1};
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd47) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 6'd0;
            rx_q       <= 47'd0;
            wcnt_q     <= '0;
            resp_vld_q <= 1'b0;
            tx_q       <= 48'd0;
            index_q    <= 6'd0;
            arg_q      <= 32'd0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
            crcf_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            wcnt_q     <= wcnt_d;
            resp_vld_q <= resp_vld_d;
            tx_q       <= tx_d;
            index_q    <= index_d;
            arg_q      <= arg_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef SD_CMD_CRC_CHECK_EN
            crcf_q     <= crcf_d;
`endif
        end
    end

    assign ocmd_oe    = (state_q == S_TX);
    assign ocmd_sd    = ocmd_oe ? tx_q[47] : 1'b1;
    assign obusy      = (state_q != S_IDLE);
    assign ocmd_index = index_q;
    assign ocmd_arg   = arg_q;
    assign ocmd_valid = valid_q;
    assign oframe_err = ferr_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Bench for sd_cmd_responder: fixed vectors, randomized commands against a timing/outcome model, reset corner case.
module tb_sd_cmd_responder;

    localparam int NCR   = 2;
    localparam int TMO   = 64;
    localparam int LIMIT = 120;
    localparam int BIG   = 100000;
    localparam int K_ACC = 0, K_FERR = 1, K_DROP = 2, K_CRC = 3;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        icmd_sd = 1'b1;
    logic        irespond = 1'b0;
    logic        iskip = 1'b0;
    logic [5:0]  iresp_index = 6'd0;
    logic [31:0] iresp_arg = 32'd0;
    logic        ocmd_sd, ocmd_oe, ocmd_valid, ocrc_fail, oframe_err, obusy;
    logic [5:0]  ocmd_index;
    logic [31:0] ocmd_arg;

    sd_cmd_responder #(.NCR(NCR), .NCR_TIMEOUT(TMO)) dut (
        .iclk(iclk), .irst(irst), .icmd_sd(icmd_sd),
        .ocmd_sd(ocmd_sd), .ocmd_oe(ocmd_oe),
        .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg),
        .ocmd_valid(ocmd_valid), .ocrc_fail(ocrc_fail), .oframe_err(oframe_err),
        .irespond(irespond), .iskip(iskip),
        .iresp_index(iresp_index), .iresp_arg(iresp_arg),
        .obusy(obusy)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic [47:0] frame;
        int          rd;     // irespond at rel = 2+rd (-1: never)
        int          sd;     // iskip at rel = 2+sd (-1: never)
        logic [5:0]  ridx;
        logic [31:0] rarg;
    } stim_t;

    typedef struct {
        int          n_valid;
        int          n_crc;
        int          n_ferr;
        int          pulse_rel;
        logic [5:0]  idx;
        logic [31:0] arg;
        int          oe_first;
        int          oe_cnt;
        logic [47:0] bits;
        int          busy_last;
        int          line_bad;
    } obs_t;

    typedef struct {
        stim_t       s;
        int          kind;
        int          start;
        int          blast;
        logic [47:0] resp;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [5:0]  last_idx = 6'd0;
    logic [31:0] last_arg = 32'd0;
    vec_t        tv[12];

    // CRC7 as polynomial long division of data*x^7 by x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] m;
        m = {d, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (m[i]) m = m ^ (47'h89 << (i - 7));
        return m[6:0];
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] resp_of(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CMD_CRC_CHECK_EN
        return {2'b00, idx, arg, crc7_ref({2'b00, idx, arg}), 1'b1};
`else
        return {2'b00, idx, arg, 7'h7F, 1'b1};
`endif
    endfunction

    function automatic obs_t expand(input int kind, input logic [47:0] f, input int start,
                                    input int blast, input logic [47:0] resp);
        obs_t e;
        e.n_valid   = (kind == K_ACC) ? 1 : 0;
        e.n_crc     = (kind == K_CRC) ? 1 : 0;
        e.n_ferr    = (kind == K_FERR) ? 1 : 0;
        e.pulse_rel = (kind == K_DROP) ? -1 : 2;
        e.idx       = f[45:40];
        e.arg       = f[39:8];
        e.oe_first  = start;
        e.oe_cnt    = (start >= 0) ? 48 : 0;
        e.bits      = (start >= 0) ? resp : 48'd0;
        e.busy_last = blast;
        e.line_bad  = 0;
        return e;
    endfunction

    // Outcome and timing from the protocol rules; rel counts negedges after the end bit was driven.
    function automatic obs_t model(input stim_t s);
        int kind, rr, rs, ts, start, blast;
        if (!s.frame[0])       kind = K_FERR;
        else if (!s.frame[46]) kind = K_DROP;
`ifdef SD_CMD_CRC_CHECK_EN
        else if (s.frame[7:1] != crc7_ref(s.frame[47:8])) kind = K_CRC;
`endif
        else                   kind = K_ACC;
        start = -1;
        blast = 1;
        if (kind == K_ACC) begin
            rr = (s.rd >= 0) ? 2 + s.rd : BIG;
            rs = (s.sd >= 0) ? 2 + s.sd : BIG;
            ts = (rr <= TMO) ? ((rr + 1 > NCR + 1) ? rr + 1 : NCR + 1) : BIG;
            if (rs < ts && rs <= TMO) blast = rs;
            else if (ts != BIG) begin
                start = ts;
                blast = ts + 47;
            end else blast = TMO;
        end
        return expand(kind, s.frame, start, blast, resp_of(s.ridx, s.rarg));
    endfunction

    function automatic vec_t mkv(input logic [47:0] f, input int rd, input int sd,
                                 input logic [5:0] ri, input logic [31:0] ra, input int kind,
                                 input int start, input int blast, input logic [47:0] resp);
        vec_t v;
        v.s.frame = f; v.s.rd = rd; v.s.sd = sd; v.s.ridx = ri; v.s.rarg = ra;
        v.kind = kind; v.start = start; v.blast = blast; v.resp = resp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered and left on a negedge; samples outputs first, then drives inputs for the next cycle.
    task automatic run_cmd(input stim_t s, input int tx_hint, output obs_t o);
        o.n_valid = 0; o.n_crc = 0; o.n_ferr = 0; o.pulse_rel = -1;
        o.idx = 6'd0; o.arg = 32'd0; o.oe_first = -1; o.oe_cnt = 0;
        o.bits = 48'd0; o.busy_last = 0; o.line_bad = 0;
        iresp_index = s.ridx;
        iresp_arg   = s.rarg;
        for (int i = 47; i >= 0; i--) begin
            icmd_sd = s.frame[i];
            @(negedge iclk);
        end
        icmd_sd = 1'b1;
        for (int r = 1; r <= LIMIT; r++) begin
            if (ocmd_valid) begin
                o.n_valid++; o.pulse_rel = r; o.idx = ocmd_index; o.arg = ocmd_arg;
            end
            if (ocrc_fail)  begin o.n_crc++;  o.pulse_rel = r; end
            if (oframe_err) begin o.n_ferr++; o.pulse_rel = r; end
            if (ocmd_oe) begin
                if (o.oe_first < 0) o.oe_first = r;
                o.oe_cnt++;
                o.bits = {o.bits[46:0], ocmd_sd};
            end else if (ocmd_sd !== 1'b1) o.line_bad++;
            if (obusy) o.busy_last = r;
            irespond = (s.rd >= 0 && r == 2 + s.rd);
            iskip    = (s.sd >= 0 && r == 2 + s.sd);
            // the line is ours to ignore while the card drives it
            icmd_sd  = (tx_hint > 0 && r >= tx_hint && r < tx_hint + 48) ? 1'b0 : 1'b1;
            @(negedge iclk);
        end
        irespond = 1'b0;
        iskip    = 1'b0;
        icmd_sd  = 1'b1;
    endtask

    task automatic check_obs(input string tag, input obs_t e, input obs_t o);
        chk({tag, ".valid"},     64'(o.n_valid),   64'(e.n_valid));
        chk({tag, ".crcfail"},   64'(o.n_crc),     64'(e.n_crc));
        chk({tag, ".frameerr"},  64'(o.n_ferr),    64'(e.n_ferr));
        chk({tag, ".pulse_at"},  64'(o.pulse_rel), 64'(e.pulse_rel));
        if (e.n_valid == 1) begin
            chk({tag, ".index"}, 64'(o.idx), 64'(e.idx));
            chk({tag, ".arg"},   64'(o.arg), 64'(e.arg));
            last_idx = e.idx;
            last_arg = e.arg;
        end
        chk({tag, ".oe_first"},  64'(o.oe_first),  64'(e.oe_first));
        chk({tag, ".oe_cnt"},    64'(o.oe_cnt),    64'(e.oe_cnt));
        if (e.oe_cnt == 48) chk({tag, ".resp"}, 64'(o.bits), 64'(e.bits));
        chk({tag, ".busy_last"}, 64'(o.busy_last), 64'(e.busy_last));
        chk({tag, ".line_idle"}, 64'(o.line_bad),  64'(0));
        chk({tag, ".hold_idx"},  64'(ocmd_index),  64'(last_idx));
        chk({tag, ".hold_arg"},  64'(ocmd_arg),    64'(last_arg));
    endtask

    initial begin
        logic [47:0] cmd0, cmd8, r0, r8;
        obs_t        e, o;
        stim_t       s;
        logic [5:0]  idx;
        logic [31:0] arg;
        int          c, bp;

        cmd0 = 48'h400000000095;
        cmd8 = 48'h48000001AA87;
`ifdef SD_CMD_CRC_CHECK_EN
        r0 = 48'h000000000001;
        r8 = 48'h08000001AA13;
        tv[2] = mkv(48'h48000001AA85, 0, -1, 6'd8, 32'h1AA, K_CRC, -1, 1, 48'd0);
`else
        r0 = 48'h0000000000FF;
        r8 = 48'h08000001AAFF;
        tv[2] = mkv(48'h48000001AA85, 0, -1, 6'd8, 32'h1AA, K_ACC, 3, 50, r8);
`endif
        tv[0]  = mkv(cmd0, 0, -1, 6'd0, 32'd0, K_ACC, 3, 50, r0);
        tv[1]  = mkv(cmd8, 0, -1, 6'd8, 32'h1AA, K_ACC, 3, 50, r8);
        tv[3]  = mkv(48'h48000001AA86, 0, -1, 6'd8, 32'h1AA, K_FERR, -1, 1, 48'd0);
        tv[4]  = mkv(cmd0, 10, -1, 6'd0, 32'd0, K_ACC, 13, 60, r0);
        tv[5]  = mkv(cmd0, -1, -1, 6'd0, 32'd0, K_ACC, -1, 64, 48'd0);
        tv[6]  = mkv(48'h08000001AA13, 0, -1, 6'd8, 32'h1AA, K_DROP, -1, 1, 48'd0);
        tv[7]  = mkv(cmd0, 0, 0, 6'd0, 32'd0, K_ACC, -1, 2, 48'd0);
        tv[8]  = mkv(cmd0, 62, -1, 6'd0, 32'd0, K_ACC, 65, 112, r0);
        tv[9]  = mkv(cmd0, 63, -1, 6'd0, 32'd0, K_ACC, -1, 64, 48'd0);
        tv[10] = mkv(cmd8, 3, 10, 6'd8, 32'h1AA, K_ACC, 6, 53, r8);
        tv[11] = mkv(cmd0, -1, 5, 6'd0, 32'd0, K_ACC, -1, 7, 48'd0);

        #2 irst = 1'b0;
        repeat (3) @(negedge iclk);
        chk("rst.sd",     64'(ocmd_sd),    64'(1));
        chk("rst.oe",     64'(ocmd_oe),    64'(0));
        chk("rst.valid",  64'(ocmd_valid), 64'(0));
        chk("rst.crc",    64'(ocrc_fail),  64'(0));
        chk("rst.ferr",   64'(oframe_err), 64'(0));
        chk("rst.busy",   64'(obusy),      64'(0));
        chk("rst.index",  64'(ocmd_index), 64'(0));
        chk("rst.arg",    64'(ocmd_arg),   64'(0));
        irst = 1'b1;
        repeat (2) @(negedge iclk);

        for (int n = 0; n < 12; n++) begin
            e = expand(tv[n].kind, tv[n].s.frame, tv[n].start, tv[n].blast, tv[n].resp);
            run_cmd(tv[n].s, e.oe_first, o);
            check_obs($sformatf("v%0d", n), e, o);
        end

        for (int n = 0; n < 40; n++) begin
            idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            s.frame = mk_cmd(idx, arg);
            c = int'($urandom_range(0, 9));
            if (c == 0) s.frame[0] = 1'b0;
            else if (c == 1) s.frame[46] = 1'b0;
            else if (c == 2) begin
                bp = int'($urandom_range(1, 7));
                s.frame[bp] = ~s.frame[bp];
            end
            if ($urandom_range(0, 7) == 0) s.rd = -1;
            else if ($urandom_range(0, 3) == 0) s.rd = int'($urandom_range(0, 70));
            else s.rd = int'($urandom_range(0, 12));
            s.sd = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : -1;
            s.ridx = 6'($urandom_range(0, 63));
            s.rarg = $urandom;
            e = model(s);
            run_cmd(s, e.oe_first, o);
            check_obs($sformatf("r%0d", n), e, o);
        end

        // reset while bit 20 of a response is on the line
        iresp_index = 6'd0;
        iresp_arg   = 32'd0;
        for (int i = 47; i >= 0; i--) begin
            icmd_sd = cmd0[i];
            @(negedge iclk);
        end
        icmd_sd = 1'b1;
        for (int r = 1; r < 23; r++) begin
            irespond = (r == 2);
            @(negedge iclk);
        end
        irespond = 1'b0;
        chk("arst.tx_active", 64'(ocmd_oe), 64'(1));
        irst = 1'b0;
        #1;
        chk("arst.oe",    64'(ocmd_oe),    64'(0));
        chk("arst.sd",    64'(ocmd_sd),    64'(1));
        chk("arst.busy",  64'(obusy),      64'(0));
        chk("arst.index", 64'(ocmd_index), 64'(0));
        chk("arst.arg",   64'(ocmd_arg),   64'(0));
        last_idx = 6'd0;
        last_arg = 32'd0;
        @(negedge iclk);
        irst = 1'b1;
        @(negedge iclk);
        e = expand(tv[0].kind, tv[0].s.frame, tv[0].start, tv[0].blast, tv[0].resp);
        run_cmd(tv[0].s, e.oe_first, o);
        check_obs("post_rst", e, o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
